dmem_arbiter: RTL
=================

# dmem_arbiter

Sits in front of the 16K×32 data RAM, which is clocked on the falling edge of `clock`. Shares the RAM between the CPU load/store port and the UART program loader. Converts CPU byte stores into a two-cycle read-modify-write, because the RAM has a single whole-word write enable. Outputs a stall to the CPU whenever its access cannot finish in the current cycle.

## Interface
- `STARVE_LIMIT`, default 8: cycles a pending loader request waits before it is force-granted.
- `clock` in 1: system clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_read` in 1: CPU load request.
- `cpu_write` in 1: CPU store request. `cpu_read` and `cpu_write` are never both high.
- `cpu_byte` in 1: 1 = byte store, 0 = word store. Ignored for reads.
- `cpu_addr` in 32: byte address. Word index is [15:2]; byte lane is [1:0].
- `cpu_wdata` in 32: store data. A byte store uses [7:0].
- `cpu_rdata` out 32: load data.
- `cpu_stall` out 1: combinational. CPU holds all request inputs unchanged while it is high.
- `ld_req` in 1: loader request, level. Held until `ld_ack`.
- `ld_we` in 1: 1 = write, 0 = read.
- `ld_addr` in 14: word index.
- `ld_wdata` in 32: loader write data.
- `ld_rdata` out 32: registered loader read data.
- `ld_ack` out 1: registered one-cycle completion pulse.
- `ram_addr` out 14: to RAM.
- `ram_din` out 32: to RAM.
- `ram_we` out 1: to RAM.
- `ram_dout` in 32: from RAM.

## Operation
- **RAM contract:** the address presented during cycle N is read or written at the falling edge inside cycle N. `ram_dout` is valid before the rising edge that ends cycle N.
- **States:** IDLE, RMW_WR, LD_GRANT.
- **IDLE, CPU owns the RAM** when `cpu_read|cpu_write` and the starve counter is below `STARVE_LIMIT`.
  - Read: `ram_addr = cpu_addr[15:2]`; `cpu_rdata = ram_dout`; no stall.
  - Word store: `ram_we = 1`, `ram_din = cpu_wdata`; no stall.
  - Byte store: `ram_we = 0`; `cpu_stall = 1`.
    - Register `merge` = `ram_dout` with lane `cpu_addr[1:0]` replaced by `cpu_wdata[7:0]`.
    - Lane 0 = bits [7:0], up to lane 3 = bits [31:24].
    - Next state RMW_WR.
- **RMW_WR:**
  - `ram_addr = cpu_addr[15:2]`, `ram_we = 1`, `ram_din = merge`, `cpu_stall = 0`.
  - Next state IDLE.
  - Loader is not granted in this state.
- **IDLE, loader granted** when `ld_req` and either no CPU request, or starve counter = `STARVE_LIMIT`.
  - Next state LD_GRANT.
  - If the CPU is requesting in this cycle, `cpu_stall = 1` and the RAM is not accessed.
- **LD_GRANT:**
  - `ram_addr = ld_addr`; `ram_we = ld_we`; `ram_din = ld_wdata`.
  - `cpu_stall = cpu_read|cpu_write`.
  - Register `ld_rdata <= ram_dout` on reads only; it is held on writes.
  - `ld_ack <= 1`; starve counter cleared; next state IDLE.
- **Starve counter:**
  - Increments, saturating at `STARVE_LIMIT`, each cycle `ld_req` is high and the loader is not granted.
  - Cleared on grant and whenever `ld_req = 0`.
- **Back-to-back loader:** the loader must drop `ld_req` or present a new request after `ld_ack`. The IDLE cycle following LD_GRANT gives the CPU the next slot.
- **Idle outputs:** `cpu_rdata` = `ram_dout` at all times; it is meaningful only on an unstalled read. In IDLE with no request, `ram_we = 0` and `ram_addr = cpu_addr[15:2]`.

## Timing
- **Reset values:**
  - Outputs: `cpu_stall = 0`, `ld_ack = 0`, `ld_rdata = 0`, `ram_we = 0`.
  - Internal: state IDLE, `merge = 0`, starve counter 0.
- **Reset mid-operation:** a pending RMW_WR write or loader grant is abandoned with no RAM write. Reset wins over all other events.
- **CPU latency:**
  - Read and word store: 0 extra cycles.
  - Byte store: 1 stall cycle, write lands in the second cycle.
- **Loader latency:**
  - `ld_ack` is asserted 2 cycles after the grant decision cycle: grant, then LD_GRANT, then ack visible.
  - Worst-case wait from `ld_req` to grant is `STARVE_LIMIT` + 2 cycles under continuous CPU traffic.
- **Simultaneous requests in IDLE:** the CPU wins unless the counter is saturated.
- **Address range:** addresses use bits [15:2] only; upper bits are ignored and wrap silently.

## Test plan
- **Word store/load:** word store 0xDEADBEEF to 0x0000_0010, then load 0x10 → `cpu_rdata` = 0xDEADBEEF; `cpu_stall` never high.
- **Byte store RMW:** word 0x11223344 at 0x20, then byte store 0xAA to 0x22 → stall exactly 1 cycle; a following load returns 0x11AA3344.
- **Idle-CPU loader:** loader writes 0xCAFEF00D to index 5 with the CPU idle → `ld_ack` pulses once, 2 cycles after `ld_req` rises. CPU load of 0x14 → 0xCAFEF00D. Loader read of index 5 → `ld_rdata` = 0xCAFEF00D.
- **Starvation:** CPU loads every cycle while `ld_req` is held → loader granted on cycle 9 (`STARVE_LIMIT` = 8). `cpu_stall` is high for exactly 2 cycles; the CPU load then completes with the correct data.
- **Contention with byte store:** `ld_req` rises during a byte store's first cycle → RMW_WR completes first and memory holds the merged word; the loader is granted no earlier than the following IDLE cycle.
- **Reset in RMW_WR:** assert `reset` during RMW_WR → no RAM write (target word unchanged); all outputs at reset values next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: shares the falling-edge 16Kx32 RAM between the CPU load/store
// port and the UART loader, turning CPU byte stores into a two-cycle read-modify-write.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic        cpu_byte,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [13:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] ld_rdata,
  output logic        ld_ack,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  input  logic [31:0] ram_dout
);

  // state      | meaning
  // S_IDLE     | CPU access, byte-store read phase, or loader grant decision
  // S_RMW_WR   | write back the merged word of a byte store
  // S_LD_GRANT | loader owns the RAM for one cycle
  typedef enum logic [1:0] {S_IDLE, S_RMW_WR, S_LD_GRANT} state_t;

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_starve, w_starve_nxt;
  logic [31:0]   r_merge, w_merge_nxt;
  logic          r_ld_ack;
  logic [31:0]   r_ld_rdata;
  logic          w_cpu_req;
  logic          w_sat;
  logic          w_ld_grant;
  logic          w_unused;

  assign w_cpu_req = cpu_read | cpu_write;
  assign w_sat     = (r_starve == CW'(STARVE_LIMIT));
  assign w_unused  = ^cpu_addr[31:16];
  assign cpu_rdata = ram_dout;
  assign ld_ack    = r_ld_ack;
  assign ld_rdata  = r_ld_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_merge_nxt = r_merge;
    w_ld_grant  = 1'b0;
    ram_addr    = cpu_addr[15:2];
    ram_din     = cpu_wdata;
    ram_we      = 1'b0;
    cpu_stall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The ack cycle still sees the old ld_req level, so it must not re-grant.
        w_ld_grant = ld_req && !r_ld_ack && (!w_cpu_req || w_sat);
        if (w_ld_grant) begin
          cpu_stall   = w_cpu_req;
          w_state_nxt = S_LD_GRANT;
        end else if (cpu_write) begin
          if (cpu_byte) begin
            cpu_stall   = 1'b1;
            w_merge_nxt = ram_dout;
            case (cpu_addr[1:0])
              2'd0:    w_merge_nxt[7:0]   = cpu_wdata[7:0];
              2'd1:    w_merge_nxt[15:8]  = cpu_wdata[7:0];
              2'd2:    w_merge_nxt[23:16] = cpu_wdata[7:0];
              default: w_merge_nxt[31:24] = cpu_wdata[7:0];
            endcase
            w_state_nxt = S_RMW_WR;
          end else begin
            ram_we = 1'b1;
          end
        end
      end
      S_RMW_WR: begin
        ram_we      = 1'b1;
        ram_din     = r_merge;
        w_state_nxt = S_IDLE;
      end
      S_LD_GRANT: begin
        ram_addr    = ld_addr;
        ram_we      = ld_we;
        ram_din     = ld_wdata;
        cpu_stall   = w_cpu_req;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset must also suppress the write of an in-flight RMW or loader grant.
    if (reset) begin
      ram_we    = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (!ld_req || w_ld_grant || (r_state == S_LD_GRANT))
      w_starve_nxt = '0;
    else if (!w_sat)
      w_starve_nxt = r_starve + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_merge    <= '0;
      r_starve   <= '0;
      r_ld_ack   <= 1'b0;
      r_ld_rdata <= '0;
    end else begin
      r_merge  <= w_merge_nxt;
      r_starve <= w_starve_nxt;
      r_ld_ack <= (r_state == S_LD_GRANT);
      if ((r_state == S_LD_GRANT) && !ld_we)
        r_ld_rdata <= ram_dout;
    end
  end

endmodule
